// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES step-through round sequencer: phase
// encoding, per-key-size round counts and the selector decode.
package aes_seq_pkg;

    typedef enum logic [1:0] {
        PH_ENC  = 2'd0,
        PH_DEC  = 2'd1,
        PH_DONE = 2'd2
    } phase_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Highest global step index (AES-256: 2*14+1).
    localparam logic [4:0] MAX_ROUND = 5'd29;

    // Selector 3 is unused on the board and falls back to AES-128.
    function automatic logic [3:0] nr_for_sel(input logic [1:0] sel);
        logic [3:0] nr;
        case (sel)
            2'd1:    nr = NR_192;
            2'd2:    nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_key_debouncer.sv
// Push-button front end: 2-FF synchronizer, stability counter and a one-cycle
// pulse on each accepted press. Releases are debounced but never pulse.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // Internal level convention: 1 = pressed, regardless of board polarity.
    logic key_norm;
    assign key_norm = KEY_ACTIVE_LOW ? ~key_raw_i : key_raw_i;

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    // Count consecutive disagreeing samples; the last one flips the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Synchronizer and debounce state; reset leaves the key "released".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_norm;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/aes_round_sequencer.sv
// Round sequencer for the step-through AES demo. Turns debounced key presses
// into steps and walks cipher rounds 0..Nr, decipher rounds 0..Nr, then DONE.
// Optional auto-stepping is compiled in with AES_ROUND_SEQ_AUTO_STEP_EN.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned AUTO_PERIOD     = 50000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_raw_i,
    input  logic [1:0] sel_i,
    input  logic       auto_run_i,
    output logic       step_o,
    output logic [4:0] round_o,
    output logic [3:0] enc_round_o,
    output logic [3:0] dec_round_o,
    output logic [1:0] phase_o,
    output logic [3:0] nr_o,
    output logic       done_o
);

    logic       btn_step;
    logic       step;
    logic [1:0] sel_q;
    logic [3:0] nr_cur;
    logic       restart;

    phase_e     phase_q, phase_d;
    logic [4:0] round_q, round_d;
    logic [3:0] enc_q, enc_d;
    logic [3:0] dec_q, dec_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_key_debouncer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .key_raw_i (key_raw_i),
        .press_o   (btn_step)
    );

    assign nr_cur = nr_for_sel(sel_q);
    // Only a change of round count matters; sel 0 <-> 3 is not a restart.
    assign restart = (nr_for_sel(sel_i) != nr_cur);

`ifdef AES_ROUND_SEQ_AUTO_STEP_EN
    localparam int unsigned AutoW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_PERIOD - 1);

    logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;
    logic             auto_tick_q, auto_tick_d;

    // Free-running period counter while auto_run is held; wrap emits a tick.
    always_comb begin
        auto_cnt_d  = '0;
        auto_tick_d = 1'b0;
        if (auto_run_i && !restart) begin
            if (auto_cnt_q == AutoLast) begin
                auto_tick_d = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + AutoW'(1);
            end
        end
    end

    // Auto-step counter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            auto_cnt_q  <= '0;
            auto_tick_q <= 1'b0;
        end else begin
            auto_cnt_q  <= auto_cnt_d;
            auto_tick_q <= auto_tick_d;
        end
    end

    // A coincident button press and auto tick merge into one step.
    assign step = btn_step | auto_tick_q;
`else
    logic unused_auto_run;
    assign unused_auto_run = auto_run_i & (AUTO_PERIOD != 0);
    assign step = btn_step;
`endif

    // Phase/round next state; restart outranks a same-cycle step.
    always_comb begin
        phase_d = phase_q;
        round_d = round_q;
        enc_d   = enc_q;
        dec_d   = dec_q;
        if (restart) begin
            phase_d = PH_ENC;
            round_d = '0;
            enc_d   = '0;
            dec_d   = '0;
        end else if (step) begin
            case (phase_q)
                PH_ENC: begin
                    if (round_q < MAX_ROUND) begin
                        round_d = round_q + 5'd1;
                        if (round_q == {1'b0, nr_cur}) begin
                            phase_d = PH_DEC;
                            enc_d   = nr_cur;
                            dec_d   = '0;
                        end else begin
                            enc_d = enc_q + 4'd1;
                        end
                    end
                end
                PH_DEC: begin
                    if (dec_q == nr_cur) begin
                        phase_d = PH_DONE;
                    end else if (round_q < MAX_ROUND) begin
                        round_d = round_q + 5'd1;
                        dec_d   = dec_q + 4'd1;
                    end
                end
                PH_DONE: begin
                    phase_d = PH_DONE;
                end
                default: begin
                    phase_d = PH_ENC;
                    round_d = '0;
                    enc_d   = '0;
                    dec_d   = '0;
                end
            endcase
        end
    end

    // Sequencer state; sel is sampled every cycle, even in reset, so nr is valid.
    always_ff @(posedge clk_i) begin
        sel_q <= sel_i;
        if (rst_i) begin
            phase_q <= PH_ENC;
            round_q <= '0;
            enc_q   <= '0;
            dec_q   <= '0;
        end else begin
            phase_q <= phase_d;
            round_q <= round_d;
            enc_q   <= enc_d;
            dec_q   <= dec_d;
        end
    end

    assign step_o      = step;
    assign round_o     = round_q;
    assign enc_round_o = enc_q;
    assign dec_round_o = dec_q;
    assign phase_o     = phase_q;
    assign nr_o        = nr_cur;
    assign done_o      = (phase_q == PH_DONE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a short debounce window.
module tb_aes_round_sequencer;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_raw;
    logic [1:0] sel;
    logic       auto_run;
    logic       step;
    logic [4:0] round;
    logic [3:0] enc_round;
    logic [3:0] dec_round;
    logic [1:0] phase;
    logic [3:0] nr;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    aes_round_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .KEY_ACTIVE_LOW  (1'b1),
        .AUTO_PERIOD     (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_raw_i   (key_raw),
        .sel_i       (sel),
        .auto_run_i  (auto_run),
        .step_o      (step),
        .round_o     (round),
        .enc_round_o (enc_round),
        .dec_round_o (dec_round),
        .phase_o     (phase),
        .nr_o        (nr),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        bit         set_sel;
        logic [1:0] sel;
        int         presses;
        logic [4:0] round;
        logic [3:0] enc;
        logic [3:0] dec;
        logic [1:0] phase;
        logic       done;
        logic [3:0] nr;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] s);
        sel     = s;
        key_raw = 1'b1;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One clean press and release, long enough for both to be debounced.
    task automatic press(output int n);
        n       = 0;
        key_raw = 1'b0;
        repeat (DEB + 4) begin
            tick();
            if (step) n++;
        end
        key_raw = 1'b1;
        repeat (DEB + 4) begin
            tick();
            if (step) n++;
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] r, input logic [3:0] e,
                             input logic [3:0] d, input logic [1:0] p, input logic dn,
                             input logic [3:0] n);
        check({tag, " round"}, 32'(round), 32'(r));
        check({tag, " enc_round"}, 32'(enc_round), 32'(e));
        check({tag, " dec_round"}, 32'(dec_round), 32'(d));
        check({tag, " phase"}, 32'(phase), 32'(p));
        check({tag, " done"}, 32'(done), 32'(dn));
        check({tag, " nr"}, 32'(nr), 32'(n));
    endtask

    initial begin
        int steps;
        int one;
        bit found;

        //         rst  set  sel   n   round enc  dec  ph    dn    nr
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 0,  5'd0,  4'd0,  4'd0,  2'd0, 1'b0, 4'd10};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 10, 5'd10, 4'd10, 4'd0,  2'd0, 1'b0, 4'd10};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 1,  5'd11, 4'd10, 4'd0,  2'd1, 1'b0, 4'd10};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 10, 5'd21, 4'd10, 4'd10, 2'd1, 1'b0, 4'd10};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 1,  5'd21, 4'd10, 4'd10, 2'd2, 1'b1, 4'd10};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 1,  5'd21, 4'd10, 4'd10, 2'd2, 1'b1, 4'd10};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 0,  5'd0,  4'd0,  4'd0,  2'd0, 1'b0, 4'd14};
        vecs[7]  = '{1'b0, 1'b0, 2'd2, 14, 5'd14, 4'd14, 4'd0,  2'd0, 1'b0, 4'd14};
        vecs[8]  = '{1'b0, 1'b0, 2'd2, 1,  5'd15, 4'd14, 4'd0,  2'd1, 1'b0, 4'd14};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 14, 5'd29, 4'd14, 4'd14, 2'd1, 1'b0, 4'd14};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 1,  5'd29, 4'd14, 4'd14, 2'd2, 1'b1, 4'd14};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 1,  5'd29, 4'd14, 4'd14, 2'd2, 1'b1, 4'd14};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 0,  5'd0,  4'd0,  4'd0,  2'd0, 1'b0, 4'd10};
        vecs[13] = '{1'b0, 1'b0, 2'd3, 3,  5'd3,  4'd3,  4'd0,  2'd0, 1'b0, 4'd10};
        vecs[14] = '{1'b0, 1'b1, 2'd0, 0,  5'd3,  4'd3,  4'd0,  2'd0, 1'b0, 4'd10};
        vecs[15] = '{1'b0, 1'b1, 2'd1, 0,  5'd0,  4'd0,  4'd0,  2'd0, 1'b0, 4'd12};

        rst      = 1'b1;
        key_raw  = 1'b1;
        sel      = 2'd0;
        auto_run = 1'b0;

        // Reset values and exact press-to-step latency.
        do_reset(2'd0);
        check("reset step", 32'(step), 32'd0);
        check_all("reset", 5'd0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd10);
        key_raw = 1'b0;
        steps   = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            if (step) steps++;
        end
        check("latency no early step", 32'(steps), 32'd0);
        tick();
        check("latency step at edge5", 32'(step), 32'd1);
        check("latency round before update", 32'(round), 32'd0);
        tick();
        check("latency step one cycle", 32'(step), 32'd0);
        check("latency round", 32'(round), 32'd1);
        check("latency enc_round", 32'(enc_round), 32'd1);
        key_raw = 1'b1;
        steps   = 0;
        repeat (12) begin
            tick();
            if (step) steps++;
        end
        check("release no step", 32'(steps), 32'd0);
        check("release round", 32'(round), 32'd1);

        // Short glitches never get through.
        do_reset(2'd0);
        steps = 0;
        repeat (5) begin
            key_raw = 1'b0;
            repeat (3) begin
                tick();
                if (step) steps++;
            end
            key_raw = 1'b1;
            repeat (3) begin
                tick();
                if (step) steps++;
            end
        end
        repeat (6) begin
            tick();
            if (step) steps++;
        end
        check("glitch steps", 32'(steps), 32'd0);
        check("glitch round", 32'(round), 32'd0);

        // Table of press sequences and selector changes.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].do_rst) begin
                do_reset(vecs[i].sel);
            end else if (vecs[i].set_sel) begin
                sel = vecs[i].sel;
                tick();
                tick();
            end
            steps = 0;
            for (int p = 0; p < vecs[i].presses; p++) begin
                press(one);
                steps += one;
            end
            check($sformatf("row%0d steps", i), 32'(steps), 32'(vecs[i].presses));
            check_all($sformatf("row%0d", i), vecs[i].round, vecs[i].enc, vecs[i].dec,
                      vecs[i].phase, vecs[i].done, vecs[i].nr);
        end

        // Selector change while step is high: restart wins, step is dropped.
        do_reset(2'd1);
        for (int p = 0; p < 5; p++) press(one);
        check("selstep pre round", 32'(round), 32'd5);
        key_raw = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (step) found = 1'b1;
        end
        check("selstep step seen", 32'(found), 32'd1);
        sel = 2'd2;
        tick();
        check_all("selstep", 5'd0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd14);
        key_raw = 1'b1;
        repeat (DEB + 4) tick();
        check("selstep round held", 32'(round), 32'd0);

        // Reset in DEC mid-press: outputs clear and the debouncer starts over.
        do_reset(2'd1);
        for (int p = 0; p < 15; p++) press(one);
        check("rstdec pre round", 32'(round), 32'd15);
        check("rstdec pre dec_round", 32'(dec_round), 32'd2);
        check("rstdec pre phase", 32'(phase), 32'd1);
        key_raw = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstdec step", 32'(step), 32'd0);
        check_all("rstdec", 5'd0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd12);
        steps = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            if (step) steps++;
        end
        check("rstdec no early step", 32'(steps), 32'd0);
        tick();
        check("rstdec fresh step", 32'(step), 32'd1);
        tick();
        check("rstdec round after step", 32'(round), 32'd1);
        key_raw = 1'b1;
        repeat (DEB + 4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Upstream control stage for the step-through AES demo. It debounces the raw push-button, turns each press into a single-cycle step pulse, and owns the shared round counter that the cipher, decipher and display datapaths consume. The key size is taken from the switch-based selector; the block walks cipher rounds 0..Nr, then decipher rounds 0..Nr, and then holds in DONE.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a level change (20 ms at 50 MHz)
KEY_ACTIVE_LOW, 1, 1 = key_raw low means pressed
AUTO_PERIOD, 50000000, cycles between auto steps (used only with the optional feature)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
key_raw  input  1  asynchronous raw push-button
sel  input  2  key size: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = treated as 0
auto_run  input  1  auto-step enable; ignored unless the optional feature is compiled in
step  output  1  one-cycle pulse per accepted press or auto tick
round  output  5  global step index, 0..2*Nr+1
enc_round  output  4  cipher round, 0..Nr; holds Nr once the block leaves ENC
dec_round  output  4  decipher round, 0..Nr; 0 while in ENC
phase  output  2  0 = ENC, 1 = DEC, 2 = DONE
nr  output  4  10, 12 or 14 for the active selector
done  output  1  high while phase is DONE

Behaviour:
- Reset values: step 0, round 0, enc_round 0, dec_round 0, phase ENC, done 0, nr from the current sel.
- Reset also clears the synchronizers and the debounce counter, and sets the debounced level to "released".
- Clock and reset use the single clk and the synchronous, active-high rst; there are no asynchronous paths other than key_raw.
- Synchronizer: 2-FF synchronizer on key_raw, polarity normalised by KEY_ACTIVE_LOW.
- Debounce counter:
  - Counts while the synchronized level differs from the debounced level.
  - Clears to 0 on any cycle where the two agree.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Step timing:
  - Edge 0 is the first edge at which sync stage 1 samples "pressed".
  - The debounced level flips at edge DEBOUNCE_CYCLES+1.
  - step is high for exactly the cycle after that edge.
  - The state and round update at edge DEBOUNCE_CYCLES+2.
  - Releases never generate a step.
- Nr decode: nr = 10 / 12 / 14 for sel 0 / 1 / 2; sel 3 gives 10.
- FSM:
  - ENC: each step increments round. When round reaches Nr, the next step moves to DEC with round = Nr+1.
  - DEC: dec_round = round - (Nr+1). The step that makes dec_round = Nr is the last step in DEC; the following step moves to DONE.
  - DONE: further steps are ignored; round stays 2*Nr+1.
- Outputs: round, enc_round, dec_round and phase are registered and mutually consistent in every cycle. round never exceeds 29.
- Selector change:
  - sel is registered every cycle.
  - Any change of the decoded Nr triggers a restart on the next edge: round 0, phase ENC.
  - Restart has priority over a step in the same cycle; that step is dropped.
  - A sel change between 0 and 3 changes nothing, because both decode to Nr = 10.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES cycles produces no step and resets the counter.
- Reset mid-operation: rst wins over everything, including a step in the same cycle.

Optional Feature:
AES_ROUND_SEQ_AUTO_STEP_EN
- Defined:
  - A free-running counter of AUTO_PERIOD cycles runs while auto_run = 1.
  - Each wrap produces a step identical to a button step.
  - If a button step and an auto tick coincide, a single step results.
  - Deasserting auto_run clears the counter.
  - Restart and rst also clear the counter.
- Undefined: auto_run is ignored, no auto counter exists, and behaviour is button-only.

Decomposition:
- Shared package aes_seq_pkg, containing:
  - phase encoding constants PH_ENC, PH_DEC, PH_DONE;
  - NR_128 = 10, NR_192 = 12, NR_256 = 14;
  - function nr_for_sel;
  - MAX_ROUND = 29.
- One natural sub-module: key_debouncer, covering the synchronizer, debounce counter and press-edge pulse, with DEBOUNCE_CYCLES and KEY_ACTIVE_LOW as parameters.

Test Plan (DEBOUNCE_CYCLES = 4, KEY_ACTIVE_LOW = 1):
- Reset, sel = 0, then key_raw held low from edge 0 -> step high only in the cycle after edge 5; round = 1 and enc_round = 1 after edge 6; no step on release.
- key_raw low pulses lasting 3 cycles, repeated 5 times -> no step; round stays 0.
- sel = 0, 22 clean presses -> phase ENC through round 10, DEC at round 11 (dec_round 0), dec_round = 10 at round 21, DONE at press 22 with round held at 21 and done = 1.
- sel = 2, 30 presses -> DONE with round = 29, enc_round = 14, dec_round = 14; a 31st press leaves everything unchanged.
- sel = 1 at round 5, then sel -> 2 in the same cycle that step is high -> round 0, phase ENC, nr = 14; the step is discarded.
- rst asserted for 1 cycle while in DEC at round 15, sel = 1 -> all outputs return to their reset values on the next cycle; the debouncer requires a fresh 4-cycle stable press before the next step.
